// File: rtl/calc_sequencer_fsm.sv
// Keypad sequencer for the 4-digit BCD calculator: collects operand A, operator and operand B
// from key strobes and drives the adder/subtractor operands and result-stage selects.
module calc_sequencer_fsm #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned W_BIN    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [W_BIN-1:0]        operand_a,
  output logic [W_BIN-1:0]        operand_b,
  output logic                    operator,
  output logic                    is_res,
  output logic [4*N_DIGITS-1:0]   entry_bcd,
  output logic [1:0]              state,
  output logic                    ovf
);

  localparam int unsigned CntW = $clog2(N_DIGITS + 1);
  localparam logic [W_BIN:0] MaxVal = (W_BIN + 1)'(10 ** N_DIGITS - 1);

  localparam logic [3:0] KeyPlus  = 4'd10;
  localparam logic [3:0] KeyMinus = 4'd11;
  localparam logic [3:0] KeyEq    = 4'd12;
  localparam logic [3:0] KeyClr   = 4'd13;

  typedef enum logic [1:0] {
    StEnterA  = 2'b00,
    StEnterB  = 2'b01,
    StShowRes = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [W_BIN-1:0]        op_a_q, op_a_d;
  logic [W_BIN-1:0]        op_b_q, op_b_d;
  logic                    oper_q, oper_d;
  logic                    is_res_q, is_res_d;
  logic                    ovf_q, ovf_d;
  logic [4*N_DIGITS-1:0]   entry_q, entry_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic                    is_digit;
  logic                    is_opkey;
  logic                    can_shift;
  logic [W_BIN-1:0]        digit_bin;
  logic [4*N_DIGITS-1:0]   entry_shift;
  logic [W_BIN:0]          sum;

  always_comb begin
    is_digit    = key_code < 4'd10;
    is_opkey    = (key_code == KeyPlus) || (key_code == KeyMinus);
    can_shift   = cnt_q < CntW'(N_DIGITS);
    digit_bin   = W_BIN'(key_code);
    entry_shift = {entry_q[4*N_DIGITS-5:0], key_code};
    sum         = {1'b0, op_a_q} + {1'b0, op_b_q};
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    oper_d   = oper_q;
    is_res_d = is_res_q;
    ovf_d    = ovf_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;

    if (key_valid) begin
      if (key_code == KeyClr) begin
        state_d  = StEnterA;
        op_a_d   = '0;
        op_b_d   = '0;
        oper_d   = 1'b0;
        is_res_d = 1'b0;
        ovf_d    = 1'b0;
        entry_d  = '0;
        cnt_d    = '0;
      end else begin
        case (state_q)
          StEnterA: begin
            if (is_digit && can_shift) begin
              op_a_d  = op_a_q * W_BIN'(10) + digit_bin;
              entry_d = entry_shift;
              cnt_d   = cnt_q + CntW'(1);
            end else if (is_opkey) begin
              oper_d  = (key_code == KeyPlus);
              entry_d = '0;
              cnt_d   = '0;
              state_d = StEnterB;
            end
          end
          StEnterB: begin
            if (is_digit && can_shift) begin
              op_b_d  = op_b_q * W_BIN'(10) + digit_bin;
              entry_d = entry_shift;
              cnt_d   = cnt_q + CntW'(1);
            end else if (is_opkey && (cnt_q == '0)) begin
              oper_d = (key_code == KeyPlus);
            end else if (key_code == KeyEq) begin
              is_res_d = 1'b1;
              // Subtraction never overflows here; its sign is handled downstream.
              ovf_d    = oper_q && (sum > MaxVal);
              state_d  = StShowRes;
            end
          end
          StShowRes: begin
            if (is_digit) begin
              op_a_d   = digit_bin;
              op_b_d   = '0;
              entry_d  = {{(4*N_DIGITS-4){1'b0}}, key_code};
              cnt_d    = CntW'(1);
              is_res_d = 1'b0;
              ovf_d    = 1'b0;
              state_d  = StEnterA;
            end
          end
          default: state_d = StEnterA;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEnterA;
      op_a_q   <= '0;
      op_b_q   <= '0;
      oper_q   <= 1'b0;
      is_res_q <= 1'b0;
      ovf_q    <= 1'b0;
      entry_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      oper_q   <= oper_d;
      is_res_q <= is_res_d;
      ovf_q    <= ovf_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign operand_a = op_a_q;
  assign operand_b = op_b_q;
  assign operator  = oper_q;
  assign is_res    = is_res_q;
  assign ovf       = ovf_q;
  assign entry_bcd = entry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_calc_sequencer_fsm.sv
// Bench for calc_sequencer_fsm: directed key sequences plus random keys against a
// digit-list reference model of the calculator entry rules.
module tb_calc_sequencer_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [13:0] operand_a, operand_b;
  logic        op_sel, is_res, ovf;
  logic [15:0] entry_bcd;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = typing A, 1 = typing B, 2 = result shown.
  int m_phase, m_a, m_b, m_op, m_res, m_ovf;
  int digs[$];

  always #5 clk = ~clk;

  calc_sequencer_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operator  (op_sel),
    .is_res    (is_res),
    .entry_bcd (entry_bcd),
    .state     (state),
    .ovf       (ovf)
  );

  function automatic int dec_val();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function automatic int bcd_val();
    int v = 0;
    foreach (digs[i]) v = v * 16 + digs[i];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_ovf = 0;
    digs.delete();
  endtask

  task automatic model_key(input bit r, input bit v, input int c);
    if (r || (v && c == 13)) begin
      model_reset();
    end else if (v) begin
      if (m_phase == 0) begin
        if (c < 10) begin
          if (digs.size() < 4) begin
            digs.push_back(c);
            m_a = dec_val();
          end
        end else if (c == 10 || c == 11) begin
          m_op = (c == 10);
          digs.delete();
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (c < 10) begin
          if (digs.size() < 4) begin
            digs.push_back(c);
            m_b = dec_val();
          end
        end else if ((c == 10 || c == 11) && digs.size() == 0) begin
          m_op = (c == 10);
        end else if (c == 12) begin
          m_res = 1;
          m_ovf = (m_op == 1) && (m_a + m_b > 9999);
          m_phase = 2;
        end
      end else if (c < 10) begin
        digs.delete();
        digs.push_back(c);
        m_a = c; m_b = 0; m_res = 0; m_ovf = 0;
        m_phase = 0;
      end
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, int'(state), m_phase);
    check({tag, ".a"}, int'(operand_a), m_a);
    check({tag, ".b"}, int'(operand_b), m_b);
    check({tag, ".op"}, int'(op_sel), m_op);
    check({tag, ".res"}, int'(is_res), m_res);
    check({tag, ".ovf"}, int'(ovf), m_ovf);
    check({tag, ".bcd"}, int'(entry_bcd), bcd_val());
  endtask

  // One clock cycle of stimulus; outputs sampled just after the edge.
  task automatic step(input bit r, input bit v, input int c, input string tag);
    @(negedge clk);
    rst = r; key_valid = v; key_code = 4'(c);
    @(posedge clk);
    model_key(r, v, c);
    #1;
    check_all(tag);
  endtask

  task automatic press(input int c);
    step(1'b0, 1'b1, c, "key");
  endtask

  task automatic press_seq(input int seq[$]);
    foreach (seq[i]) press(seq[i]);
  endtask

  initial begin
    model_reset();
    step(1'b1, 1'b0, 0, "rst");
    check("rst_state", int'(state), 0);

    press_seq('{1, 2, 3, 10, 4, 5, 12});
    check("t1_a", int'(operand_a), 123);
    check("t1_b", int'(operand_b), 45);
    check("t1_state", int'(state), 2);

    press(13);
    press_seq('{9, 8, 7, 6, 5});
    check("t2_a", int'(operand_a), 9876);
    check("t2_bcd", int'(entry_bcd), 'h9876);

    press(13);
    press_seq('{9, 9, 9, 9, 10, 1, 12});
    check("t3_ovf", int'(ovf), 1);
    press(7);
    check("t3_new_a", int'(operand_a), 7);
    check("t3_new_res", int'(is_res), 0);

    press(13);
    press_seq('{5, 10, 11, 3, 12});
    check("t4_op", int'(op_sel), 0);
    press(13);
    press_seq('{5, 11, 3, 10});
    check("t4_op_hold", int'(op_sel), 0);
    check("t4_state", int'(state), 1);

    press_seq('{4, 10, 2, 13});
    check("t5_clr_a", int'(operand_a), 0);
    press_seq('{4, 10, 2});
    step(1'b1, 1'b1, 7, "rst_key");
    check("t5_rst_b", int'(operand_b), 0);

    press_seq('{1, 2, 15});
    check("t6_a", int'(operand_a), 12);
    step(1'b0, 1'b0, 3, "idle");

    for (int i = 0; i < 800; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, $urandom_range(0, 1), $urandom_range(0, 15), "rnd_rst");
      else if (r < 5)  step(1'b0, 1'b1, 13, "rnd_clr");
      else if (r < 60) step(1'b0, 1'b1, (r % 3 == 0) ? 9 : $urandom_range(0, 9), "rnd_dig");
      else if (r < 72) step(1'b0, 1'b1, $urandom_range(10, 11), "rnd_op");
      else if (r < 82) step(1'b0, 1'b1, 12, "rnd_eq");
      else if (r < 87) step(1'b0, 1'b1, $urandom_range(14, 15), "rnd_rsv");
      else             step(1'b0, 1'b0, $urandom_range(0, 15), "rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_sequencer_fsm.md
Name: calc_sequencer_fsm

Overview:
Keypad-driven sequencer for the 4-digit BCD calculator datapath. It collects operand A, the operator and operand B from single-cycle key events. It drives the binary operands to the adder/subtractor and the `operator` / `is_res` selects to the result mux/BCD converter stage. It also exports the BCD image of the operand currently being typed, for the display path while no result is shown.

Parameters:
- N_DIGITS, 4, maximum decimal digits per operand.
- W_BIN, 14, binary operand width; must hold 10^N_DIGITS-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear, 14-15 reserved.
- operand_a  out  W_BIN  binary operand A to the datapath.
- operand_b  out  W_BIN  binary operand B to the datapath.
- operator  out  1  1 = suma, 0 = resta.
- is_res  out  1  1 = result stage shows the result; 0 = zero.
- entry_bcd  out  4*N_DIGITS  BCD digits of the operand being typed, MS digit in top nibble.
- state  out  2  00 ENTER_A, 01 ENTER_B, 10 SHOW_RES.
- ovf  out  1  registered with is_res; 1 when operator=1 and A+B > 10^N_DIGITS-1.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On rst at a clk edge, every output is 0 and state = ENTER_A. This applies even mid-entry or with key_valid high in the same cycle; rst wins.
- Latency:
  - All outputs are registered.
  - A key sampled at edge k is reflected at all outputs after edge k.
- Key sampling:
  - Keys are sampled only when key_valid=1, and each high cycle is one key.
  - Reserved codes (14, 15) change nothing.
- Per-operand digit counter cnt (0..N_DIGITS). A digit key with cnt < N_DIGITS does all of the following:
  - operand = operand*10 + digit (exact, never exceeds W_BIN).
  - entry_bcd shifts left one nibble, with the new digit in the LS nibble.
  - cnt increments.
  - With cnt = N_DIGITS the digit is ignored; there is no wrap.
- Clear (13): from any state, same effect as rst.
- ENTER_A:
  - Digit: accumulate into operand_a.
  - '+' or '-': operator = 1 or 0; entry_bcd = 0; cnt = 0; go to ENTER_B. An empty A is accepted as 0.
  - '=': ignored.
- ENTER_B:
  - Digit: accumulate into operand_b.
  - '+' or '-' with cnt = 0: replaces operator; state is unchanged.
  - '+' or '-' with cnt > 0: ignored.
  - '=': is_res = 1; ovf computed from the current A and B; go to SHOW_RES. An empty B is accepted as 0.
- SHOW_RES:
  - Digit: starts a new calculation. operand_a = digit, operand_b = 0, entry_bcd = digit, cnt = 1, is_res = 0, ovf = 0, operator holds; go to ENTER_A.
  - '+', '-', '=': ignored.
- operand_a, operand_b and operator are stable throughout SHOW_RES.
- The subtraction sign (B > A) is the datapath's concern; ovf is 0 for resta.

Test Plan:
- rst, then keys 1,2,3,'+',4,5,'=' -> operand_a=123, operand_b=45, operator=1, is_res=1, ovf=0, state=10.
- Keys 9,8,7,6,5 in ENTER_A -> operand_a=9876, entry_bcd=16'h9876, and the fifth key has no effect.
- Keys 9,9,9,9,'+',1,'=' -> ovf=1, is_res=1. Then key 7 -> state=00, operand_a=7, operand_b=0, is_res=0, ovf=0.
- Keys 5,'+','-',3,'=' -> operator=0 (replaced), operand_b=3. The sequence 5,'-',3,'+' leaves operator=0 and state=01.
- Keys 4,'+',2 then clear, and separately rst asserted while key_valid=1 with key_code=7 -> all outputs 0, state=00 on the next cycle.
- Back-to-back key_valid on consecutive cycles with keys 1,2 -> operand_a=12; key_code 15 is ignored.
